// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, word widths,
// PC increment and the opcode/funct field positions used by the decoder.
// No ports; imported with "import mips_pkg::*".
package mips_pkg;

    localparam int INSTR_W = 32;

    // Byte increment between sequential instruction words.
    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

    // Field positions inside an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // Fetch FSM states. Explicit encodings keep the values stable for any
    // legacy logic that decodes the state vector directly.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer behind it.
// Latency: a load or skid pop is visible the cycle after it is requested.
// Backpressure: contents hold while stall_i is high; the skid absorbs one word.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          drop both the IF/ID entry and the skid entry
//   load_i           write instr_i/pc_plus4_i straight into IF/ID
//   skid_load_i      write instr_i/pc_plus4_i into the skid buffer
//   skid_pop_i       move the skid entry into IF/ID
//   stall_i          downstream is not consuming IF/ID this cycle
//   instr_i          incoming instruction word
//   pc_plus4_i       PC of instr_i plus 4
//   id_valid_o       IF/ID holds a live instruction
//   id_instr_o       IF/ID instruction
//   id_pc_plus4_o    IF/ID PC plus 4
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               skid_load_i,
    input  logic               skid_pop_i,
    input  logic               stall_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc_plus4_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [INSTR_W-1:0] id_pc_plus4_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc4_q,   pc4_d;

    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [INSTR_W-1:0] skid_pc4_q,   skid_pc4_d;

    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (flush_i) begin
            // Data fields are left alone; only the valid bits matter.
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (load_i) begin
                valid_d = 1'b1;
                instr_d = instr_i;
                pc4_d   = pc_plus4_i;
            end else if (skid_pop_i && skid_valid_q) begin
                valid_d      = 1'b1;
                instr_d      = skid_instr_q;
                pc4_d        = skid_pc4_q;
                skid_valid_d = 1'b0;
            end else if (valid_q && !stall_i) begin
                // Consumed downstream with nothing new behind it.
                valid_d = 1'b0;
            end

            if (skid_load_i) begin
                skid_valid_d = 1'b1;
                skid_instr_d = instr_i;
                skid_pc4_d   = pc_plus4_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc4_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign id_valid_o    = valid_q;
    assign id_instr_o    = instr_q;
    assign id_pc_plus4_o = pc4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC, req/ack word reads from imem, IF/ID register feed.
// Latency: IF/ID valid the cycle after imem_ack; one word/cycle on zero-wait memory.
// Backpressure: id_stall with a full IF/ID parks one word in a skid and stops requesting.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     read request and word address, held until imem_ack
//   imem_ack/rdata    read completion and instruction word
//   redirect_valid/pc taken branch or jump from downstream; flush and restart
//   id_stall          downstream cannot accept IF/ID this cycle
//   id_valid/instr    IF/ID register contents
//   id_opcode/funct   instruction fields for the control unit
//   id_pc_plus4       PC of id_instr plus 4
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    input  logic               id_stall,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [5:0]         id_opcode,
    output logic [5:0]         id_funct,
    output logic [INSTR_W-1:0] id_pc_plus4
);

    localparam logic [INSTR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[INSTR_W-1:2], 2'b00};

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;             // next PC to fetch
    logic [INSTR_W-1:0] req_addr_q, req_addr_d; // address presented to imem
    logic               arm_q, arm_d;           // IDLE has seen its first clock

    logic               slot_free;
    logic [INSTR_W-1:0] redirect_tgt;
    logic [INSTR_W-1:0] pc_inc;
    logic               load;
    logic               skid_load;
    logic               skid_pop;

    assign slot_free    = !id_valid || !id_stall;
    assign redirect_tgt = word_align(redirect_pc);
    assign pc_inc       = pc_q + PC_INC;  // wraps modulo 2^32

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        arm_d     = arm_q;
        load      = 1'b0;
        skid_load = 1'b0;
        skid_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                // The first edge after reset release only arms the FSM, so
                // the first request leaves on the second edge.
                arm_d = 1'b1;
                if (arm_q) begin
                    state_d = FETCH;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // Without an ack the request is still outstanding and
                    // must complete before the new PC can be issued.
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!id_stall) begin
                    skid_pop = 1'b1;
                    state_d  = FETCH;
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                // The returning word belongs to the abandoned path.
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The request address follows the PC except while draining, where the
    // abandoned request must keep its original address until its ack.
    assign req_addr_d = (state_d == DRAIN) ? req_addr_q : pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            req_addr_q <= RESET_PC_ALIGNED;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            arm_q      <= arm_d;
        end
    end

    // A redirect in any state drops the IF/ID entry and the skid buffer.
    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (redirect_valid),
        .load_i        (load),
        .skid_load_i   (skid_load),
        .skid_pop_i    (skid_pop),
        .stall_i       (id_stall),
        .instr_i       (imem_rdata),
        .pc_plus4_i    (pc_inc),
        .id_valid_o    (id_valid),
        .id_instr_o    (id_instr),
        .id_pc_plus4_o (id_pc_plus4)
    );

    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = req_addr_q;
    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus a
// randomized run scored against an in-order instruction-stream model.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [31:0] id_pc_plus4;

    int errors = 0;
    int checks = 0;

    // Memory model knobs: extra wait cycles before ack, and constant-data mode.
    int mem_wait = 0;
    bit const_mode = 1'b0;
    int wait_cnt = 0;

    instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_funct       (id_funct),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (const_mode) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: acks after mem_wait idle cycles of a held request.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Advance to just after the next falling edge (inputs and sampling point).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reset, then return at the first cycle with a request outstanding.
    task automatic apply_reset();
        rst_n = 1'b0;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        step();
    endtask

    task automatic test_reset();
        mem_wait = 0;
        const_mode = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 00000000", id_pc_plus4); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL first_edge_req: got %0b want 0", imem_req); end
        @(posedge clk); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL second_edge_req: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait();
        mem_wait = 0;
        const_mode = 1'b1;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL zw_addr[%0d]: got req=%0b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k)); end
            checks++; if (id_valid !== (k > 0)) begin
                errors++; $display("FAIL zw_valid[%0d]: got %0b want %0b", k, id_valid, (k > 0)); end
            if (k > 0) begin
                checks++; if (id_opcode !== 6'h00 || id_funct !== 6'h20 || id_pc_plus4 !== 32'(4 * k)) begin
                    errors++; $display("FAIL zw_fields[%0d]: got op=%h fn=%h pc4=%h want op=00 fn=20 pc4=%h",
                                       k, id_opcode, id_funct, id_pc_plus4, 32'(4 * k)); end
            end
            step();
        end
        const_mode = 1'b0;
    endtask

    task automatic test_latency();
        mem_wait = 2;
        const_mode = 1'b0;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 3) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
                    errors++; $display("FAIL lat_hold0[%0d]: got req=%0b addr=%h vld=%0b want 1/00000000/0", c, imem_req, imem_addr, id_valid); end
            end else if (c < 6) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                    errors++; $display("FAIL lat_hold4[%0d]: got req=%0b addr=%h want 1/00000004", c, imem_req, imem_addr); end
            end
            if (c == 3) begin
                checks++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h4 || id_instr !== memf(32'h0)) begin
                    errors++; $display("FAIL lat_first: got vld=%0b pc4=%h instr=%h want 1/00000004/%h", id_valid, id_pc_plus4, id_instr, memf(32'h0)); end
            end
            if (c == 6) begin
                checks++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h8 || id_instr !== memf(32'h4)) begin
                    errors++; $display("FAIL lat_second: got vld=%0b pc4=%h instr=%h want 1/00000008/%h", id_valid, id_pc_plus4, id_instr, memf(32'h4)); end
            end
            step();
        end
        mem_wait = 0;
    endtask

    task automatic test_stall_hold();
        mem_wait = 0;
        apply_reset();
        id_stall = 1'b1;                       // c0
        step();                                // c1
        checks++; if (id_valid !== 1'b1 || id_instr !== memf(32'h0)) begin
            errors++; $display("FAIL stall_load: got vld=%0b instr=%h want 1/%h", id_valid, id_instr, memf(32'h0)); end
        step();                                // c2
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_req_c2: got %0b want 0", imem_req); end
        step();                                // c3
        checks++; if (imem_req !== 1'b0 || id_instr !== memf(32'h0)) begin
            errors++; $display("FAIL stall_hold_c3: got req=%0b instr=%h want 0/%h", imem_req, id_instr, memf(32'h0)); end
        step();                                // c4
        id_stall = 1'b0;
        step();                                // c5
        checks++; if (id_valid !== 1'b1 || id_instr !== memf(32'h4) || id_pc_plus4 !== 32'h8) begin
            errors++; $display("FAIL stall_skid_out: got vld=%0b instr=%h pc4=%h want 1/%h/00000008", id_valid, id_instr, id_pc_plus4, memf(32'h4)); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL stall_resume: got req=%0b addr=%h want 1/00000008", imem_req, imem_addr); end
        step();                                // c6
        checks++; if (id_instr !== memf(32'h8) || id_pc_plus4 !== 32'hC) begin
            errors++; $display("FAIL stall_next: got instr=%h pc4=%h want %h/0000000c", id_instr, id_pc_plus4, memf(32'h8)); end
    endtask

    task automatic test_redirect_drain();
        mem_wait = 0;
        apply_reset();
        step(); step(); step();                // c3: request to 0xC acked
        mem_wait = 3;
        step();                                // c4
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL drain_pre: got req=%0b addr=%h want 1/00000010", imem_req, imem_addr); end
        id_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();                                // c5
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b0) begin
            errors++; $display("FAIL drain_c5: got req=%0b addr=%h vld=%0b want 1/00000010/0", imem_req, imem_addr, id_valid); end
        step();                                // c6
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drain_c6_addr: got %h want 00000010", imem_addr); end
        step();                                // c7: old request acked
        step();                                // c8
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || id_valid !== 1'b0) begin
            errors++; $display("FAIL drain_new_addr: got req=%0b addr=%h vld=%0b want 1/00000040/0", imem_req, imem_addr, id_valid); end
        mem_wait = 0;
        step();                                // c9
        step();                                // c10
        checks++; if (id_valid !== 1'b1 || id_instr !== memf(32'h40) || id_pc_plus4 !== 32'h44) begin
            errors++; $display("FAIL drain_first: got vld=%0b instr=%h pc4=%h want 1/%h/00000044", id_valid, id_instr, id_pc_plus4, memf(32'h40)); end
    endtask

    task automatic test_redirect_ack_hold();
        mem_wait = 0;
        apply_reset();
        step();                                // c1: ack for 0x4 this cycle
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();                                // c2
        redirect_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++; $display("FAIL redir_ack: got vld=%0b req=%0b addr=%h want 0/1/00000080", id_valid, imem_req, imem_addr); end
        step();                                // c3
        checks++; if (id_valid !== 1'b1 || id_instr !== memf(32'h80) || id_pc_plus4 !== 32'h84) begin
            errors++; $display("FAIL redir_ack_first: got vld=%0b instr=%h pc4=%h want 1/%h/00000084", id_valid, id_instr, id_pc_plus4, memf(32'h80)); end
        id_stall = 1'b1;
        step();                                // c4: in HOLD
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_hold_req: got %0b want 0", imem_req); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;                 // low bits must be ignored
        step();                                // c5
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL redir_hold: got vld=%0b req=%0b addr=%h want 0/1/00000200", id_valid, imem_req, imem_addr); end
        step();                                // c6
        checks++; if (id_valid !== 1'b1 || id_instr !== memf(32'h200) || id_pc_plus4 !== 32'h204) begin
            errors++; $display("FAIL redir_hold_first: got vld=%0b instr=%h pc4=%h want 1/%h/00000204", id_valid, id_instr, id_pc_plus4, memf(32'h200)); end
    endtask

    task automatic test_reset_mid_wrap();
        mem_wait = 0;
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();                                // c1
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_top: got %h want fffffffc", imem_addr); end
        step();                                // c2
        checks++; if (imem_addr !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== memf(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap: got addr=%h pc4=%h instr=%h want 00000000/00000000/%h", imem_addr, id_pc_plus4, id_instr, memf(32'hFFFF_FFFC)); end
        mem_wait = 5;
        step();                                // c3: request to 0x4 pending
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got req=%0b addr=%h vld=%0b instr=%h pc4=%h want all zero",
                               imem_req, imem_addr, id_valid, id_instr, id_pc_plus4); end
        mem_wait = 0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        st;
        logic        rv;
        int          consumed;
        mem_wait = 0;
        const_mode = 1'b0;
        apply_reset();
        exp_pc = 32'h0;
        consumed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            mem_wait = $urandom_range(0, 2);
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            tgt = 32'($urandom_range(0, 1023));
            checks++; if (imem_addr[1:0] !== 2'b00) begin
                errors++; $display("FAIL rnd_align[%0d]: got addr=%h want low bits 00", cyc, imem_addr); end
            // The word in IF/ID is taken downstream at the coming edge.
            if (id_valid && !st && !rv) begin
                checks++; if (id_instr !== memf(exp_pc) || id_pc_plus4 !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_stream[%0d]: got instr=%h pc4=%h want %h/%h",
                                       cyc, id_instr, id_pc_plus4, memf(exp_pc), exp_pc + 32'd4); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rv) exp_pc = {tgt[31:2], 2'b00};
            id_stall = st;
            redirect_valid = rv;
            redirect_pc = tgt;
            step();
        end
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (consumed < 60) begin
            errors++; $display("FAIL rnd_progress: got %0d instructions want at least 60", consumed); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_ack_hold();
        test_reset_mid_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
